// File: rtl/cic_interp.sv
// CIC interpolator: comb chain at the input rate, R-fold zero stuffing,
// pipelined integrator chain at the clk rate, and power-of-two gain
// normalisation with saturation to the output width.
module cic_interp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned N_STAGES   = 3,
  parameter int unsigned R          = 4,
  parameter int unsigned M          = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  data_out
);

  // Register growth of the full chain; every comb and integrator uses this width.
  localparam int unsigned ACC_WIDTH = DATA_WIDTH + N_STAGES * $clog2(R * M);
  localparam int unsigned CNT_WIDTH = $clog2(R);
  // Net DC gain is (R*M)^N / R, so this shift restores unity gain.
  localparam int unsigned SHIFT     = N_STAGES * $clog2(R * M) - $clog2(R);
  // Wide enough to hold both the shifted accumulator and the output limits.
  localparam int unsigned EXT_WIDTH = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 1;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(R - 1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX =
    EXT_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN =
    EXT_WIDTH'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  // Phase counter and handshake
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 accept_c;
  logic                 inject_c;
  logic [ACC_WIDTH-1:0] inj_val_c;

  // Comb delay lines: dly_q[k][0] is the newest input of comb stage k
  logic [ACC_WIDTH-1:0] dly_q [N_STAGES][M];
  logic [ACC_WIDTH-1:0] dly_d [N_STAGES][M];
  logic [ACC_WIDTH-1:0] comb_c [N_STAGES+1];

  // Integrator accumulators and their valid pipeline (v_q[k] qualifies integ_q[k])
  logic [ACC_WIDTH-1:0] integ_q [N_STAGES];
  logic [ACC_WIDTH-1:0] integ_d [N_STAGES];
  logic [N_STAGES-1:0]  v_q, v_d;

  // Output stage
  logic signed [ACC_WIDTH-1:0] shr_c;
  logic signed [EXT_WIDTH-1:0] ext_c;
  logic [OUT_WIDTH-1:0]        data_out_q, data_out_d;
  logic                        out_valid_q, out_valid_d;

  assign accept_c  = in_valid & in_ready_q;
  // Every cycle of a sample's R phases injects: the sample itself, then zeros.
  assign inject_c  = accept_c | (cnt_q != '0);
  assign inj_val_c = accept_c ? comb_c[N_STAGES] : '0;

  // Comb chain evaluated combinationally on the incoming sample
  always_comb begin
    comb_c[0] = ACC_WIDTH'($signed(data_in));
    for (int k = 0; k < N_STAGES; k++) begin
      comb_c[k+1] = comb_c[k] - dly_q[k][M-1];
    end
  end

  // Next state for phase counter, comb delay lines, integrators and valids
  always_comb begin
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    integ_d = integ_q;
    v_d     = '0;

    if (cnt_q != '0) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_WIDTH'(1);
    end else if (accept_c) begin
      cnt_d = CNT_WIDTH'(1);
    end

    if (accept_c) begin
      for (int k = 0; k < N_STAGES; k++) begin
        dly_d[k][0] = comb_c[k];
        for (int j = 1; j < M; j++) begin
          dly_d[k][j] = dly_q[k][j-1];
        end
      end
    end

    v_d[0] = inject_c;
    if (inject_c) begin
      integ_d[0] = integ_q[0] + inj_val_c;
    end
    for (int k = 1; k < N_STAGES; k++) begin
      v_d[k] = v_q[k-1];
      if (v_q[k-1]) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
    end

    in_ready_d = (cnt_d == '0);
  end

  // Gain normalisation with saturation; data_out holds when no sample is valid
  always_comb begin
    shr_c       = $signed(integ_q[N_STAGES-1]) >>> SHIFT;
    ext_c       = EXT_WIDTH'(shr_c);
    data_out_d  = data_out_q;
    out_valid_d = v_q[N_STAGES-1];
    if (v_q[N_STAGES-1]) begin
      if (ext_c > SAT_MAX) begin
        data_out_d = OUT_WIDTH'(SAT_MAX);
      end else if (ext_c < SAT_MIN) begin
        data_out_d = OUT_WIDTH'(SAT_MIN);
      end else begin
        data_out_d = OUT_WIDTH'(ext_c);
      end
    end
  end

  // State registers; reset discards every in-flight sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      v_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < N_STAGES; k++) begin
        integ_q[k] <= '0;
        for (int j = 0; j < M; j++) begin
          dly_q[k][j] <= '0;
        end
      end
    end else begin
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      v_q         <= v_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      integ_q     <= integ_d;
      dly_q       <= dly_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_cic_interp.sv
// Directed and random bench for cic_interp at N=3, R=4, M=1, 16-bit in/out.
module tb_cic_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic [15:0] data_out;

  int checks   = 0;
  int failures = 0;

  int acc_q[$];
  int obs_q[$];

  // Unit-gain impulse response of the 3-stage, R=4 chain, scaled by 16
  int hresp[10]    = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  int step_exp[10] = '{62, 187, 375, 625, 812, 937, 1000, 1000, 1000, 1000};
  int stall_exp[20] = '{62, 187, 375, 625, 812, 937, 1000, 1000, 937, 812,
                        625, 375, 187, 62, 0, 0, 0, 0, 0, 0};

  cic_interp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Record accepted inputs and produced outputs, sampled away from the edge
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      obs_q.delete();
    end else begin
      if (out_valid) obs_q.push_back(int'($signed(data_out)));
      if (in_valid && in_ready) acc_q.push_back(int'($signed(data_in)));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: direct convolution of accepted samples with the impulse response
  function automatic int model(input int k);
    int s = 0;
    for (int j = k / 4 - 2; j <= k / 4; j++) begin
      if (j >= 0 && j < acc_q.size() && (k - 4 * j) < 10) begin
        s += acc_q[j] * hresp[k - 4 * j];
      end
    end
    s = s >>> 4;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic verify_stream(input string tag, input bit full);
    int n = obs_q.size();
    if (full) check({tag, "_count"}, n, 4 * acc_q.size());
    for (int k = 0; k < n; k++) check(tag, obs_q[k], model(k));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted; returns 1 after the accept edge
  task automatic send(input int x);
    int n = 0;
    in_valid = 1'b1;
    data_in  = 16'(x);
    @(negedge clk);
    while (!in_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = '0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    idle(3);
    rst_n = 1'b1;
  endtask

  task automatic impulse(input string tag, input int amp);
    int base = 4 * acc_q.size();
    send(amp);
    repeat (3) send(0);
    idle(16);
    for (int k = 0; k < 10; k++) begin
      check(tag, (base + k < obs_q.size()) ? obs_q[base + k] : 99999,
            (amp / 16) * hresp[k]);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_data_out", 32'($signed(data_out)), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    idle(3);
    rst_n = 1'b1;

    // Impulse: latency then the 1,3,6,... shape
    send(16);
    check("lat_c1", 32'(out_valid), 0);
    idle(1);
    check("lat_c2", 32'(out_valid), 0);
    idle(1);
    check("lat_c3", 32'(out_valid), 0);
    idle(1);
    check("lat_c4_valid", 32'(out_valid), 1);
    check("lat_c4_data", 32'($signed(data_out)), 1);
    repeat (4) send(0);
    idle(16);
    for (int k = 0; k < 20; k++) begin
      check("imp_pos", (k < obs_q.size()) ? obs_q[k] : 99999, (k < 10) ? hresp[k] : 0);
    end
    impulse("imp_neg", -16);
    verify_stream("imp_stream", 1'b1);

    // DC step with in_valid held: in_ready every 4th cycle, continuous out_valid
    do_reset();
    in_valid = 1'b1;
    data_in  = 16'd1000;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      check("dc_in_ready", 32'(in_ready), (i % 4 == 0) ? 1 : 0);
      if (i >= 4) check("dc_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(8);
    for (int k = 0; k < 10; k++) begin
      check("dc_step", (k < obs_q.size()) ? obs_q[k] : 99999, step_exp[k]);
    end
    check("dc_final", 32'($signed(data_out)), 1000);
    verify_stream("dc_stream", 1'b1);

    // Stall window between two samples
    do_reset();
    send(1000);
    idle(8);
    check("stall_gap", 32'(out_valid), 0);
    idle(2);
    send(1000);
    repeat (3) send(0);
    idle(16);
    for (int k = 0; k < 20; k++) begin
      check("stall_seq", (k < obs_q.size()) ? obs_q[k] : 99999, stall_exp[k]);
    end
    verify_stream("stall_stream", 1'b1);

    // Reset asserted at phase 2 of a DC stream
    do_reset();
    in_valid = 1'b1;
    data_in  = 16'd1000;
    repeat (40) @(negedge clk);
    for (int n = 0; n < 8 && !in_ready; n++) @(negedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    verify_stream("mid_pre", 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_data_out", 32'($signed(data_out)), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    check("mid_no_output", obs_q.size(), 0);
    impulse("mid_imp", 16);
    verify_stream("mid_stream", 1'b1);

    // Full-scale negative and positive DC
    do_reset();
    in_valid = 1'b1;
    data_in  = 16'h8000;
    repeat (8000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(8);
    check("ext_neg_final", 32'($signed(data_out)), -32768);
    verify_stream("ext_neg", 1'b1);

    do_reset();
    in_valid = 1'b1;
    data_in  = 16'h7fff;
    repeat (8000) @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(8);
    check("ext_pos_final", 32'($signed(data_out)), 32767);
    verify_stream("ext_pos", 1'b1);

    // Random samples with random idle gaps
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      logic signed [15:0] rv;
      rv = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rv = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
      send(int'(rv));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
    end
    idle(16);
    verify_stream("rand", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- CIC interpolator: the transmit-side counterpart of the CIC decimator integrator chain.
- Processing order: N comb stages at the input rate, then an R-fold zero-stuffing upsampler, then N pipelined integrator stages at the clk rate, then a fixed power-of-two gain normalisation with saturation.
- Sits between a low-rate sample source and a high-rate DAC/up-conversion path in the DFE filter array.

Parameters:
- DATA_WIDTH, 16, input sample width (signed).
- OUT_WIDTH, 16, output sample width (signed).
- N_STAGES, 3, number of comb stages and number of integrator stages.
- R, 4, interpolation ratio; must be a power of 2, ≥2.
- M, 1, comb differential delay; 1 or 2.
- ACC_WIDTH, DATA_WIDTH + N_STAGES*$clog2(R*M), internal width for all comb and integrator registers (derived).

Ports:
- clk  in  1  clock, output sample rate.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  data_in carries a sample.
- in_ready  out  1  block accepts data_in this cycle.
- data_in  in  DATA_WIDTH  signed input sample.
- out_valid  out  1  data_out valid this cycle.
- data_out  out  OUT_WIDTH  signed interpolated sample.

Behaviour:
- Reset: all comb delay lines, integrator accumulators, valid pipeline, phase counter and data_out cleared to 0; out_valid=0; in_ready=1 after reset deassertion. Reset mid-operation discards all in-flight samples; no outputs appear after release until a new acceptance.
- Phase counter cnt, range 0..R-1; in_ready = (cnt==0).
- Accept = in_valid & in_ready. On accept:
  - data_in is sign-extended to ACC_WIDTH.
  - Comb chain is evaluated combinationally: c_k = c_{k-1} - c_{k-1} delayed by M accepted samples.
  - Each comb delay line shifts.
  - c_N is injected into integrator stage 1; cnt <= 1 (or stays 0 when R==1, which is not allowed).
- cnt != 0: a zero is injected into stage 1 every cycle, regardless of in_valid; cnt <= cnt+1, wrapping R-1 -> 0.
- cnt==0 and no accept: no injection (stall); integrators downstream still drain.
- Injection (sample or zero) sets valid bit v0.
- Integrator chain:
  - Stage k updates i_k <= i_k + x_k only when v_{k-1}=1, where x_1 is the injected value and x_k = i_{k-1} register.
  - v_k <= v_{k-1}.
- Arithmetic: all comb and integrator arithmetic is modulo 2^ACC_WIDTH (two's-complement wrap, no saturation); wrap is intentional and cancels across the chain.
- Output stage: registered when v_N=1.
  - SHIFT = N_STAGES*log2(R*M) - log2(R).
  - data_out <= sat_OUT_WIDTH(i_N >>> SHIFT); arithmetic shift, truncation toward -inf, then saturation to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - out_valid <= v_N, otherwise out_valid <= 0 and data_out holds its last value.
- Latency: the sample injected in cycle t appears on data_out with out_valid=1 in cycle t+N_STAGES+1.
- Throughput: exactly R outputs per accepted input. With in_valid held high, out_valid is continuously 1 in steady state and in_ready pulses 1 of every R cycles.
- No output back-pressure: the consumer must take every out_valid cycle.
- in_valid may drop at any time. Stall occurs only at cnt==0; a sample's R phases are never interrupted.

Test Plan:
- Impulse (N=3, R=4, M=1): data_in=16 once, then zeros at every in_ready -> data_out sequence 1,3,6,10,12,12,10,6,3,1, then 0s. The first out_valid occurs 4 cycles after the accept cycle. data_in=-16 -> negated sequence.
- DC step: data_in=1000 held, in_valid=1 -> after 10 transient outputs every data_out=1000; in_ready=1 on exactly every 4th cycle; out_valid stays 1.
- Extremes: data_in=-32768 held -> settles to -32768; data_in=32767 held -> settles to 32767. No saturation event and no wrap artefacts over 10^4 samples.
- Stall: accept 1000, idle in_valid=0 for 7 cycles, accept 1000 -> out_valid gaps appear only during the idle window; the output value sequence equals the no-gap run.
- Reset mid-operation: assert rst_n=0 at cnt==2 during a DC-1000 stream -> out_valid=0, data_out=0, in_ready=1 immediately. After release with in_valid=0, no out_valid; a new impulse of 16 reproduces the sequence from the first scenario.
- Random: 5000 random inputs with random in_valid gaps -> data_out matches a bit-accurate reference model sample-for-sample.
